q_sync_arbiter: RTL and testbench
=================================

// Module: q_sync_arbiter
// PURPOSE
//  - Shares one Q-flop synchronizer (q_resolver + q_output pair) between N_REQ requesters, round-robin.
//  - Per grant: steer the winner's data onto the flop, open the sample window (qf_clock),
//    wait for quiescent ack, return the resolved bit tagged with requester id.
//  - Sits between pipeline-stage request logic and the single Q-flop instance.
// PARAMETERS
//  N_REQ    4   number of requesters (2..16)
//  TIMEOUT  15  max sample-window cycles waiting for qf_ack before forced completion (>=1)
// PORTS
//  clock      in   1        system clock, all state on rising edge
//  reset      in   1        synchronous, active-high
//  req        in   N_REQ    request to sample req_data[i]; level, held until gnt[i] seen
//  req_data   in   N_REQ    per-requester data bit to be synchronized
//  gnt        out  N_REQ    one-hot grant, high from GRANT until result handshake completes
//  res_valid  out  1        result available
//  res_ready  in   1        consumer accepts result
//  res_id     out  $clog2(N_REQ)  index of serviced requester
//  res_value  out  1        resolved Q-flop output
//  res_timeout out 1        1 = ack not seen within TIMEOUT; res_value is qf_out at expiry
//  qf_data    out  1        data to Q-flop resolver
//  qf_clock   out  1        Q-flop sample/evaluate window
//  qf_ack     in   1        Q-flop quiescent acknowledge (rl_l & rh_l)
//  qf_out     in   1        Q-flop output
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, gnt=0, res_valid=0, res_id=0, res_value=0, res_timeout=0,
//    qf_data=0, qf_clock=0, rr pointer=0, timeout counter=0. Reset mid-operation aborts
//    the current service with no result.
//  - FSM IDLE -> GRANT -> EVAL -> RESULT -> IDLE.
//  - IDLE: if |req, pick first set bit at/after rr pointer (wrapping); next GRANT.
//  - GRANT (1 cycle): gnt[w]=1, qf_data=req_data[w] (registered), qf_clock=0 (setup cycle);
//    rr pointer <= (w+1) mod N_REQ.
//  - EVAL: qf_clock=1, qf_data held; counter increments each cycle.
//    qf_ack=1 -> RESULT, res_value<=qf_out, res_timeout<=0.
//    else counter==TIMEOUT-1 -> RESULT, res_value<=qf_out, res_timeout<=1.
//    Ack and expiry in the same cycle: ack wins (res_timeout=0).
//  - RESULT: qf_clock=0, res_valid=1, outputs stable until res_valid&res_ready; then gnt=0, IDLE.
//  - Minimum latency req->res_valid: 3 cycles (IDLE, GRANT, EVAL with immediate ack).
//  - Back-to-back: IDLE always visited for one cycle between services.
//  - req[w] dropped after grant: service completes normally; change in req_data[w] after
//    GRANT is ignored.
//  - qf_ack/qf_out used directly; Q-flop ack guarantees qf_out stable when sampled.
// CONFIGURATION
//  - Macro QSYNC_STATS_EN defined: adds ports sample_count[15:0], timeout_count[15:0] (out);
//    +1 on each result handshake / each timeout result; saturate at 16'hFFFF; reset to 0.
//  - Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package q_sync_pkg: state enum {IDLE, GRANT, EVAL, RESULT}; STATS_W=16 constant;
//    function for id width.
//  - Sub-module q_rr_picker: combinational req + pointer -> one-hot winner, index, any.
//  - Top holds FSM, data/result registers, timeout counter, optional stats.
// TESTING
//  - Single req[2]=1, req_data[2]=1, qf_ack=1 on first EVAL cycle, qf_out=1 ->
//    res_valid at cycle 3, res_id=2, res_value=1, res_timeout=0.
//  - req=4'b1111 held, res_ready=1 -> grant order 0,1,2,3,0; gnt always one-hot.
//  - qf_ack held 0, TIMEOUT=15 -> 15 EVAL cycles, res_timeout=1, res_value=qf_out.
//  - qf_ack rises exactly on cycle TIMEOUT-1 -> res_timeout=0 (ack wins).
//  - res_ready=0 for 5 cycles -> res_* and gnt stable; release -> IDLE next cycle.
//  - reset pulsed during EVAL -> next cycle all outputs 0, qf_clock=0, pointer 0;
//    with QSYNC_STATS_EN counters 0.

Source files
------------

// File: rtl/q_sync_arbiter_pkg.sv
// q_sync_pkg: shared state encoding, stats width and id sizing helper for q_sync_arbiter
package q_sync_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, EVAL, RESULT} state_t;
  localparam int STATS_W = 16;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/q_sync_arbiter_rr_picker.sv
// q_rr_picker: combinational round-robin pick of the first request at or after ptr
module q_rr_picker import q_sync_pkg::*; #(
  parameter int N_REQ = 4,
  localparam int IW = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW:0] pos;
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = {1'b0, ptr} + (IW+1)'(i);
      pos = (pos >= (IW+1)'(N_REQ)) ? pos - (IW+1)'(N_REQ) : pos;
      if (!any && req[pos[IW-1:0]]) begin
        idx = pos[IW-1:0];
        any = 1'b1;
      end
    end
    onehot = '0;
    onehot[idx] = any;
  end
endmodule

// File: rtl/q_sync_arbiter.sv
// q_sync_arbiter: round-robin sharing of one Q-flop synchronizer between N_REQ requesters.
// Define QSYNC_STATS_EN to add saturating sample_count/timeout_count outputs.
module q_sync_arbiter import q_sync_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int TIMEOUT = 15,
  localparam int IW = id_w(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_data,
  output logic [N_REQ-1:0] gnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IW-1:0]    res_id,
  output logic             res_value,
  output logic             res_timeout,
  output logic             qf_data,
  output logic             qf_clock,
  input  logic             qf_ack,
  input  logic             qf_out,
  output logic             busy
`ifdef QSYNC_STATS_EN
  ,
  output logic [STATS_W-1:0] sample_count,
  output logic [STATS_W-1:0] timeout_count
`endif
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_d;
  logic [IW-1:0] ptr, id, pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic pick_any, expire, done;
  logic [CW-1:0] cnt;
  q_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req(req),
    .ptr(ptr),
    .onehot(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign expire = cnt == CW'(TIMEOUT - 1);
  // ack takes priority over expiry, so a late ack still reports a clean sample
  assign done = (state == EVAL) && (qf_ack || expire);
  assign qf_clock = state == EVAL;
  assign res_valid = state == RESULT;
  assign busy = state != IDLE;
  assign res_id = id;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = pick_any ? GRANT : IDLE;
      GRANT:   state_d = EVAL;
      EVAL:    state_d = done ? RESULT : EVAL;
      RESULT:  state_d = res_ready ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt <= '0;
      id <= '0;
      ptr <= '0;
      qf_data <= 1'b0;
      cnt <= '0;
      res_value <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      if (state == IDLE && pick_any) begin
        gnt <= pick_oh;
        id <= pick_idx;
        qf_data <= req_data[pick_idx];
      end
      if (state == GRANT) ptr <= (id == IW'(N_REQ - 1)) ? '0 : id + 1'b1;
      if (state == RESULT && res_ready) gnt <= '0;
      cnt <= (state == EVAL && !done) ? cnt + 1'b1 : '0;
      if (done) begin
        res_value <= qf_out;
        res_timeout <= !qf_ack;
      end
    end
  end
`ifdef QSYNC_STATS_EN
  logic hs;
  assign hs = res_valid && res_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_count <= '0;
      timeout_count <= '0;
    end else begin
      sample_count <= (hs && sample_count != '1) ? sample_count + 1'b1 : sample_count;
      timeout_count <= (hs && res_timeout && timeout_count != '1) ? timeout_count + 1'b1 : timeout_count;
    end
  end
`endif
endmodule

// File: tb/tb_q_sync_arbiter.sv
// tb_q_sync_arbiter: transaction-level reference model of q_sync_arbiter with random services
module tb_q_sync_arbiter;
  localparam int N = 4;
  localparam int TO = 15;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0, req_data = '0, gnt;
  logic res_valid, res_ready = 1'b0, res_value, res_timeout;
  logic qf_data, qf_clock, qf_ack = 1'b0, qf_out = 1'b0, busy;
  logic [1:0] res_id;
  int n_chk = 0, n_pass = 0, ptr = 0;

  q_sync_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_value(res_value),
    .res_timeout(res_timeout), .qf_data(qf_data), .qf_clock(qf_clock), .qf_ack(qf_ack),
    .qf_out(qf_out), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_id"}, res_id, 0);
    chk({tag, "_value"}, res_value, 0);
    chk({tag, "_timeout"}, res_timeout, 0);
    chk({tag, "_qf_data"}, qf_data, 0);
    chk({tag, "_qf_clock"}, qf_clock, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // one service from an IDLE cycle: d = EVAL cycle carrying ack, ov = forced qf_out (-1 random)
  task automatic service(input logic [N-1:0] rv, input logic [N-1:0] dv, input int d,
                         input int hold, input int ov);
    int w;
    logic last, to;
    last = 1'b0;
    to = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
    req = rv;
    req_data = dv;
    w = pick(rv, ptr);
    tick;
    if (w < 0) begin
      chk("norq_busy", busy, 0);
      req = '0;
      return;
    end
    chk("grant_gnt", gnt, 1 << w);
    chk("grant_data", qf_data, dv[w]);
    chk("grant_clk", qf_clock, 0);
    chk("grant_valid", res_valid, 0);
    ptr = (w + 1) % N;
    req[w] = 1'($urandom_range(0, 1));
    req_data = ~dv;
    tick;
    for (int k = 0; k < TO; k++) begin
      chk("eval_clk", qf_clock, 1);
      chk("eval_gnt", gnt, 1 << w);
      chk("eval_data", qf_data, dv[w]);
      chk("eval_valid", res_valid, 0);
      qf_ack = (k == d);
      qf_out = (ov < 0) ? 1'($urandom_range(0, 1)) : 1'(ov);
      last = qf_out;
      to = (k != d);
      tick;
      if (k == d || k == TO - 1) break;
    end
    qf_ack = 1'b0;
    qf_out = 1'($urandom_range(0, 1));
    for (int h = 0; h <= hold; h++) begin
      chk("res_valid", res_valid, 1);
      chk("res_id", res_id, w);
      chk("res_value", res_value, last);
      chk("res_timeout", res_timeout, to);
      chk("res_gnt", gnt, 1 << w);
      chk("res_clk", qf_clock, 0);
      res_ready = (h == hold);
      tick;
    end
    res_ready = 1'b0;
    req = '0;
    chk("post_valid", res_valid, 0);
  endtask

  initial begin
    tick;
    tick;
    chk_all_zero("reset");
    reset = 1'b0;
    tick;
    service(4'b0100, 4'b0100, 0, 0, 1);
    for (int i = 0; i < 5; i++) service(4'b1111, 4'($urandom), 0, 0, -1);
    service(4'b0010, 4'b0010, TO + 5, 0, -1);
    service(4'b0010, 4'b0000, TO - 1, 0, -1);
    service(4'b1000, 4'b1000, 2, 5, -1);
    service(4'b1000, 4'b1000, TO + 3, 0, 1);
    req = 4'b0010;
    req_data = 4'b0010;
    tick;
    chk("pre_reset_gnt", gnt, 4'b0010);
    tick;
    chk("pre_reset_clk", qf_clock, 1);
    reset = 1'b1;
    req = '0;
    tick;
    reset = 1'b0;
    chk_all_zero("abort");
    ptr = 0;
    service(4'b1111, 4'b0001, 1, 0, -1);
    for (int i = 0; i < 300; i++)
      service(4'($urandom), 4'($urandom), $urandom_range(0, TO + 2), $urandom_range(0, 3), -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
